// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Constants and width helpers shared by the single-clock and
//               dual-clock FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 8;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  // Ceiling log2, evaluated at elaboration time for parameter sizing
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Occupancy counters need one extra bit to represent the full value DEPTH
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x WIDTH register array, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming word at the write address
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with occupancy count, almost-full /
//               almost-empty thresholds and overflow / underflow pulses.
//               Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read
//               path; otherwise the read data is registered (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DEFAULT,
  parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int PTR_WIDTH = clog2(DEPTH),
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);

  localparam logic [PTR_WIDTH:0] c_depth    = DEPTH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] c_af_level = AF_LEVEL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] c_ae_level = AE_LEVEL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] c_one      = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH:0] r_wr_ptr;
  logic [PTR_WIDTH:0] r_rd_ptr;
  logic [PTR_WIDTH:0] r_count;
  logic               r_wr_error;
  logic               r_rd_error;
  logic               w_wr_accept;
  logic               w_rd_accept;
  logic [WIDTH-1:0]   w_mem_rdata;

  // Flags come only from the registered count, so a same-cycle read never
  // frees space for a write and a same-cycle write never feeds a read.
  assign full_o         = (r_count == c_depth);
  assign empty_o        = (r_count == '0);
  assign almost_full_o  = (r_count >= c_af_level);
  assign almost_empty_o = (r_count <= c_ae_level);
  assign count_o        = r_count;
  assign wr_error_o     = r_wr_error;
  assign rd_error_o     = r_rd_error;

  assign w_wr_accept = wr_en_i & ~full_o;
  assign w_rd_accept = rd_en_i & ~empty_o;

  fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .wr_en_i (w_wr_accept),
    .waddr_i (r_wr_ptr[PTR_WIDTH-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (r_rd_ptr[PTR_WIDTH-1:0]),
    .rdata_o (w_mem_rdata)
  );

  // Pointer, occupancy and error-pulse bookkeeping
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_error <= 1'b0;
      r_rd_error <= 1'b0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + c_one;
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      r_wr_error <= wr_en_i & full_o;
      r_rd_error <= rd_en_i & empty_o;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is presented directly; forced to zero while empty
  assign rdata_o = empty_o ? '0 : w_mem_rdata;
`else
  logic [WIDTH-1:0] r_rdata;

  // Capture the head word on each accepted read and hold it otherwise
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rdata <= '0;
    end else if (w_rd_accept) begin
      r_rdata <= w_mem_rdata;
    end
  end

  assign rdata_o = r_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Self-checking bench for sync_fifo_flags. A queue-based model
//               tracks the expected contents, flags and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] rdata_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [4:0]       count_o;
  logic             wr_error_o;
  logic             rd_error_o;

  always #5 clk_i = ~clk_i;

  sync_fifo_flags #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (4),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .wr_en_i        (wr_en_i),
    .wdata_i        (wdata_i),
    .rd_en_i        (rd_en_i),
    .rdata_o        (rdata_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .wr_error_o     (wr_error_o),
    .rd_error_o     (rd_error_o)
  );

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_wr_err;
  logic             m_rd_err;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] exp_rdata();
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() == 0) return '0;
    return q[0];
`else
    return m_rdata;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_rdata  = '0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    chk({ctx, "/count"},        32'(count_o),        32'(n));
    chk({ctx, "/full"},         32'(full_o),         32'(n == DEPTH));
    chk({ctx, "/empty"},        32'(empty_o),        32'(n == 0));
    chk({ctx, "/almost_full"},  32'(almost_full_o),  32'(n >= AF));
    chk({ctx, "/almost_empty"}, 32'(almost_empty_o), 32'(n <= AE));
    chk({ctx, "/wr_error"},     32'(wr_error_o),     32'(m_wr_err));
    chk({ctx, "/rd_error"},     32'(rd_error_o),     32'(m_rd_err));
    chk({ctx, "/rdata"},        32'(rdata_o),        32'(exp_rdata()));
  endtask

  // One clock: drive at negedge, model the edge, return at next negedge
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    bit full, empty;
    wr_en_i = we;
    wdata_i = wd;
    rd_en_i = re;
    @(posedge clk_i);
    full     = (q.size() == DEPTH);
    empty    = (q.size() == 0);
    m_wr_err = we && full;
    m_rd_err = re && empty;
    if (re && !empty) m_rdata = q.pop_front();
    if (we && !full) q.push_back(wd);
    @(negedge clk_i);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  initial begin
    int wr_left, rd_left, wgap, rgap, cyc, s;
    bit we, re;
    logic [WIDTH-1:0] wd;

    // Reset state
    rst_n_i = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    wdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all("reset");
    rst_n_i = 1'b1;

    // Fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, WIDTH'(i), 1'b0);
      check_all("fill");
    end

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      check_all("drain");
    end

    // Overflow: 17 writes, last one rejected
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, WIDTH'(8'hA0 + i), 1'b0);
      check_all("overflow");
    end
    step(1'b0, '0, 1'b0);
    check_all("overflow_idle");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      check_all("overflow_drain");
    end

    // Underflow: read while empty
    step(1'b0, '0, 1'b1);
    check_all("underflow");
    step(1'b0, '0, 1'b0);
    check_all("underflow_idle");

    // Random concurrent traffic across pointer wraps
    wr_left = 40; rd_left = 40; wgap = 0; rgap = 0; cyc = 0;
    while ((wr_left > 0 || rd_left > 0) && cyc < 2000) begin
      we = (wr_left > 0) && (wgap == 0);
      re = (rd_left > 0) && (rgap == 0);
      wd = WIDTH'($urandom);
      s  = q.size();
      step(we, wd, re);
      if (we && s < DEPTH) begin
        wr_left--;
        wgap = $urandom_range(4, 0);
      end else if (wgap > 0) begin
        wgap--;
      end
      if (re && s > 0) begin
        rd_left--;
        rgap = $urandom_range(4, 0);
      end else if (rgap > 0) begin
        rgap--;
      end
      check_all("wrap");
      chk("wrap/count_le_depth", 32'(count_o <= 5'(DEPTH)), 32'd1);
      cyc++;
    end
    chk("wrap/completed", 32'(wr_left == 0 && rd_left == 0), 32'd1);

    // Reset mid-stream at count 7
    for (int i = 0; i < 7; i++) begin
      step(1'b1, WIDTH'(8'h30 + i), 1'b0);
    end
    check_all("pre_reset");
    #2 rst_n_i = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    check_all("post_reset_wr");
    step(1'b0, '0, 1'b1);
    check_all("post_reset_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
